// File: rtl/uart_game_link_if.sv
// UART PHY-side bundle for the game link stage.
// master = link stage, slave = uart_tx/uart_rx side.
interface uart_game_link_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_done, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_done, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_game_link.sv
// Game link stage: 1-byte status frames over UART, opponent decode, link timeout.
// Optional GAME_LINK_ERRCNT_EN enables the bad-header rx byte counter.
module uart_game_link #(
  parameter int          HEARTBEAT_CYCLES = 650_000,
  parameter int          TIMEOUT_CYCLES   = 3_250_000,
  parameter logic [3:0]  HEADER           = 4'hA
) (
  input  logic clk,
  input  logic rst,
  input  logic game_over,
  input  logic player_ready,
  input  logic play_selected,
  input  logic multiplayer,
  uart_game_link_if.master bus,
  output logic       victory,
  output logic       opponent_ready,
  output logic       link_up,
  output logic [7:0] rx_err_count
);

  localparam int HB_W = $clog2(HEARTBEAT_CYCLES);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [HB_W-1:0] HB_MAX = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, SEND, WAIT_DONE
  } tx_state_e;

  tx_state_e       state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      last_q, last_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic            tx_start;

  logic [TO_W-1:0] to_q, to_d;
  logic            link_q, link_d;
  logic [3:0]      opp_q, opp_d;
  logic            opp_rdy_q, opp_rdy_d;
  logic            vic_q, vic_d;

  logic [7:0] frame;
  logic       accept;

  assign frame = {HEADER, multiplayer, play_selected,
                  player_ready, game_over};
  assign accept = bus.rx_valid && (bus.rx_data[7:4] == HEADER);

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    hb_d      = (hb_q == HB_MAX) ? hb_q : hb_q + 1'b1;
    tx_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame != last_q || hb_q == HB_MAX)
          state_d = LOAD;
      end
      LOAD: begin
        tx_data_d = frame;
        last_d    = frame;
        hb_d      = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (!bus.tx_busy && !rst) begin
          tx_start = 1'b1;
          state_d  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    to_d   = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
    link_d = link_q;
    opp_d  = opp_q;
    vic_d  = vic_q;
    if (accept) begin
      to_d   = '0;
      link_d = 1'b1;
      opp_d  = bus.rx_data[3:0];
    end else if (to_q == TO_MAX) begin
      link_d = 1'b0;
      opp_d  = 4'h0;
    end
    opp_rdy_d = link_d & opp_d[1];
    // A mutual game_over is blocked by the local game_over term.
    if (!multiplayer)
      vic_d = 1'b0;
    else if (accept && bus.rx_data[0] && !opp_q[0] && !game_over)
      vic_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      last_q    <= 8'h00;
      hb_q      <= '0;
      to_q      <= '0;
      link_q    <= 1'b0;
      opp_q     <= 4'h0;
      opp_rdy_q <= 1'b0;
      vic_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      hb_q      <= hb_d;
      to_q      <= to_d;
      link_q    <= link_d;
      opp_q     <= opp_d;
      opp_rdy_q <= opp_rdy_d;
      vic_q     <= vic_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start;
  assign victory        = vic_q;
  assign opponent_ready = opp_rdy_q;
  assign link_up        = link_q;

`ifdef GAME_LINK_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.rx_valid && !accept && err_q != 8'hFF)
      err_d = err_q + 8'h01;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 8'h00;
    else     err_q <= err_d;
  end

  assign rx_err_count = err_q;
`else
  assign rx_err_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_game_link.sv
// Directed testbench for uart_game_link with short heartbeat/timeout.
// Uses immediate assertions per comparison and a linear stimulus sequence.
module tb_uart_game_link;
  logic clk = 1'b0;
  logic rst;
  logic game_over, player_ready, play_selected, multiplayer;
  logic victory, opponent_ready, link_up;
  logic [7:0] rx_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_game_link_if u_if();

  uart_game_link #(
    .HEARTBEAT_CYCLES(100),
    .TIMEOUT_CYCLES(400)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .game_over      (game_over),
    .player_ready   (player_ready),
    .play_selected  (play_selected),
    .multiplayer    (multiplayer),
    .bus            (u_if),
    .victory        (victory),
    .opponent_ready (opponent_ready),
    .link_up        (link_up),
    .rx_err_count   (rx_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output int cyc,
                            output logic [7:0] data);
    cyc = 0;
    while (u_if.tx_start !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
    data = u_if.tx_data;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    tick();
    u_if.rx_valid = 1'b0;
  endtask

  task automatic phy_complete(input int n);
    tick();
    u_if.tx_busy = 1'b1;
    repeat (n) begin
      tick();
      check("start_while_busy", u_if.tx_start, 0);
    end
    u_if.tx_busy = 1'b0;
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
  endtask

  int         cyc;
  int         cnt;
  logic [7:0] d;

  initial begin
    rst = 1'b1;
    game_over = 0; player_ready = 0;
    play_selected = 0; multiplayer = 1;
    u_if.tx_busy = 0; u_if.tx_done = 0;
    u_if.rx_data = 8'h00; u_if.rx_valid = 0;
    repeat (3) tick();
    check("rst_tx_start", u_if.tx_start, 0);
    check("rst_tx_data", u_if.tx_data, 8'h00);
    check("rst_victory", victory, 0);
    check("rst_opp_ready", opponent_ready, 0);
    check("rst_link_up", link_up, 0);
    check("rst_err_count", rx_err_count, 8'h00);

    // 1: first frame after reset, then a status change
    rst = 1'b0;
    wait_start(3, cyc, d);
    check("t1_start_seen", u_if.tx_start, 1);
    check("t1_lat_le3", cyc <= 3, 1);
    check("t1_data", d, 8'hA8);
    phy_complete(10);
    player_ready = 1'b1;
    wait_start(5, cyc, d);
    check("t1b_start_seen", u_if.tx_start, 1);
    check("t1b_latency", cyc, 2);
    check("t1b_data", d, 8'hAA);
    phy_complete(10);

    // 2: heartbeat resends with constant inputs
    for (int k = 0; k < 2; k++) begin
      wait_start(150, cyc, d);
      check("t2_start_seen", u_if.tx_start, 1);
      check("t2_period", (cyc + 12 >= 95) && (cyc + 12 <= 105), 1);
      check("t2_data", d, 8'hAA);
      phy_complete(10);
    end

    // 3: link up then timeout
    rx_byte(8'hAA);
    check("t3_link_up", link_up, 1);
    check("t3_opp_ready", opponent_ready, 1);
    repeat (395) tick();
    check("t3_link_hold", link_up, 1);
    repeat (10) tick();
    check("t3_link_drop", link_up, 0);
    check("t3_opp_drop", opponent_ready, 0);

    // 4: victory on opponent game_over rising
    rx_byte(8'hA8);
    check("t4_vic_a8", victory, 0);
    check("t4_link", link_up, 1);
    check("t4_opp_rdy", opponent_ready, 0);
    rx_byte(8'hA9);
    check("t4_vic_set", victory, 1);
    rx_byte(8'hA8);
    check("t4_vic_sticky", victory, 1);
    multiplayer = 1'b0;
    tick();
    check("t4_vic_clear", victory, 0);
    multiplayer = 1'b1;
    game_over = 1'b1;
    rx_byte(8'hA8);
    rx_byte(8'hA9);
    check("t4_both_over", victory, 0);
    game_over = 1'b0;
    tick();
    check("t4_both_after", victory, 0);

    // 5: bad headers ignored, timeout not refreshed
    rx_byte(8'hAA);
    check("t5_opp_ready", opponent_ready, 1);
    repeat (3) begin
      rx_byte(8'h5A);
      tick();
    end
    check("t5_opp_kept", opponent_ready, 1);
    check("t5_link_kept", link_up, 1);
    check("t5_no_victory", victory, 0);
`ifdef GAME_LINK_ERRCNT_EN
    check("t5_err_count", rx_err_count, 8'h03);
`else
    check("t5_err_count", rx_err_count, 8'h00);
`endif
    repeat (390) tick();
    check("t5_link_hold", link_up, 1);
    repeat (6) tick();
    check("t5_link_drop", link_up, 0);

    // 6: status change while a frame is in flight
    player_ready = 1'b1;
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    wait_start(10, cyc, d);
    check("t6_start_seen", u_if.tx_start, 1);
    check("t6_data", d, 8'hAA);
    tick();
    u_if.tx_busy = 1'b1;
    game_over = 1'b1;
    repeat (5) begin
      tick();
      check("t6_start_busy", u_if.tx_start, 0);
    end
    u_if.tx_busy = 1'b0;
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    wait_start(5, cyc, d);
    check("t6_extra_seen", u_if.tx_start, 1);
    check("t6_extra_lat", cyc, 2);
    check("t6_extra_data", d, 8'hAB);
    phy_complete(10);
    cnt = 0;
    repeat (50) begin
      tick();
      if (u_if.tx_start === 1'b1) cnt++;
    end
    check("t6_one_extra", cnt, 0);

    // 7: reset while tx_start is pending
    play_selected = 1'b1;
    wait_start(5, cyc, d);
    check("t7_start_seen", u_if.tx_start, 1);
    rst = 1'b1;
    tick();
    check("t7_rst_start", u_if.tx_start, 0);
    check("t7_rst_data", u_if.tx_data, 8'h00);
    check("t7_rst_link", link_up, 0);
    rst = 1'b0;
    wait_start(5, cyc, d);
    check("t7_post_seen", u_if.tx_start, 1);
    check("t7_post_lat", cyc, 2);
    check("t7_post_data", d, 8'hAF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
